// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles every non-clock, non-reset signal of the instruction-fetch stage:
//   the icache request/response pair, the control inputs from decode and
//   execute, and the registered IF/ID payload.
//
//   Signals
//     iREN          icache read request                (fetch -> icache)
//     iaddr[31:0]   icache address, always equal to pc (fetch -> icache)
//     ihit          icache hit, iload valid this cycle (icache -> fetch)
//     iload[31:0]   instruction word from icache       (icache -> fetch)
//     stall         decode latch not accepting         (pipeline -> fetch)
//     redirect      taken branch/jump resolved in EX   (pipeline -> fetch)
//     redirect_pc   redirect target                    (pipeline -> fetch)
//     halt          decode holds a HALT instruction    (pipeline -> fetch)
//     out_instr     registered instruction             (fetch -> decode)
//     out_pc_plus_4 registered pc+4 of out_instr       (fetch -> decode)
//     out_valid     out_instr is real (0 = bubble)     (fetch -> decode)
//     halted        fetch frozen by HALT               (fetch -> pipeline)
//
//   Modports
//     master : the fetch stage itself
//     slave  : the environment (icache plus the rest of the pipeline)
// ----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus_4;
  logic        out_valid;
  logic        halted;

  modport master (
    output iREN, iaddr, out_instr, out_pc_plus_4, out_valid, halted,
    input  ihit, iload, stall, redirect, redirect_pc, halt
  );

  modport slave (
    input  iREN, iaddr, out_instr, out_pc_plus_4, out_valid, halted,
    output ihit, iload, stall, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage pipeline, directly upstream of the
//   decode latch. Owns the PC, issues icache reads and registers the
//   {instr, pc+4, valid} payload handed to decode.
//
//   Parameters
//     PC_INIT  PC loaded on reset (low two bits forced to zero)
//     WORD_W   instruction/address width; the design is built for 32 only
//
//   Ports
//     CLK   in   rising-edge system clock
//     RST   in   synchronous, active-high reset
//     bus   fetch_stage_if.master (see the interface file for signal list)
//
//   Operation
//     FETCH  : iREN high. A hit with decode accepting moves the word into the
//              output register and advances pc. A hit while decode stalls
//              parks the word in hold_instr and moves to HOLD. A miss while
//              decode accepts emits a bubble.
//     HOLD   : iREN low; the parked word is released once stall drops.
//     HALTED : iREN low, pc frozen, redirects ignored; only RST leaves.
//   Per-cycle priority: RST > redirect > halt > stall/ihit.
//   Outputs out_* are purely registered, so there is no combinational path
//   from ihit/iload to decode. iREN/iaddr depend on state/pc (and RST) only.
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned WORD_W  = 32
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    HOLD   = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [WORD_W-1:0] ALIGN_MASK = ~32'h0000_0003;
  localparam logic [WORD_W-1:0] PC_STEP    = 32'h0000_0004;

  // Architectural state
  state_t            state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] hold_instr;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc_plus_4;
  logic              out_valid;

  // Next-state values
  state_t            state_next;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] hold_instr_next;
  logic [WORD_W-1:0] out_instr_next;
  logic [WORD_W-1:0] out_pc_plus_4_next;
  logic              out_valid_next;

  // Shared helpers
  logic [WORD_W-1:0] pc_plus_4;
  logic [WORD_W-1:0] redirect_target;

  // Sequential increment wraps modulo 2^32; redirect targets are word-aligned
  // by clearing the low two bits rather than trusting the producer.
  always_comb begin
    pc_plus_4       = pc + PC_STEP;
    redirect_target = bus.redirect_pc & ALIGN_MASK;
  end

  // Icache request and status outputs
  always_comb begin
    bus.iREN          = (state == FETCH) && !RST;
    bus.iaddr         = pc;
    bus.halted        = (state == HALTED);
    bus.out_instr     = out_instr;
    bus.out_pc_plus_4 = out_pc_plus_4;
    bus.out_valid     = out_valid;
  end

  // Next-state and payload selection
  always_comb begin
    state_next         = state;
    pc_next            = pc;
    hold_instr_next    = hold_instr;
    out_instr_next     = out_instr;
    out_pc_plus_4_next = out_pc_plus_4;
    out_valid_next     = out_valid;

    case (state)
      FETCH: begin
        if (bus.redirect) begin
          // Any same-cycle hit belongs to the wrong path and is dropped.
          pc_next         = redirect_target;
          hold_instr_next = 32'h0000_0000;
          out_instr_next  = 32'h0000_0000;
          out_valid_next  = 1'b0;
          state_next      = FETCH;
        end else if (bus.halt) begin
          state_next = HALTED;
          if (!bus.stall) begin
            out_instr_next = 32'h0000_0000;
            out_valid_next = 1'b0;
          end else begin
            out_valid_next = out_valid;
          end
        end else if (bus.ihit && !bus.stall) begin
          out_instr_next     = bus.iload;
          out_pc_plus_4_next = pc_plus_4;
          out_valid_next     = 1'b1;
          pc_next            = pc_plus_4;
        end else if (bus.ihit) begin
          // Decode is busy: park the word so the icache is not re-read.
          hold_instr_next = bus.iload;
          state_next      = HOLD;
        end else if (!bus.stall) begin
          out_instr_next = 32'h0000_0000;
          out_valid_next = 1'b0;
        end else begin
          state_next = FETCH;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          // The parked word is on the wrong path; it never reaches decode.
          pc_next         = redirect_target;
          hold_instr_next = 32'h0000_0000;
          out_instr_next  = 32'h0000_0000;
          out_valid_next  = 1'b0;
          state_next      = FETCH;
        end else if (bus.halt) begin
          state_next = HALTED;
          if (!bus.stall) begin
            out_instr_next = 32'h0000_0000;
            out_valid_next = 1'b0;
          end else begin
            out_valid_next = out_valid;
          end
        end else if (!bus.stall) begin
          out_instr_next     = hold_instr;
          out_pc_plus_4_next = pc_plus_4;
          out_valid_next     = 1'b1;
          pc_next            = pc_plus_4;
          state_next         = FETCH;
        end else begin
          state_next = HOLD;
        end
      end

      HALTED: begin
        // Drain whatever decode still holds as soon as it accepts; clearing
        // again on later cycles is harmless because the value is already zero.
        if (!bus.stall) begin
          out_instr_next = 32'h0000_0000;
          out_valid_next = 1'b0;
        end else begin
          out_valid_next = out_valid;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean fetch with a bubble.
        state_next     = FETCH;
        out_instr_next = 32'h0000_0000;
        out_valid_next = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID payload registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= FETCH;
      pc            <= PC_INIT & ALIGN_MASK;
      hold_instr    <= 32'h0000_0000;
      out_instr     <= 32'h0000_0000;
      out_pc_plus_4 <= 32'h0000_0000;
      out_valid     <= 1'b0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      hold_instr    <= hold_instr_next;
      out_instr     <= out_instr_next;
      out_pc_plus_4 <= out_pc_plus_4_next;
      out_valid     <= out_valid_next;
    end
  end

endmodule
